// File: rtl/ssram_fifo_reader.sv
// ssram_fifo_reader: first-word-fall-through FIFO built around a dual-port
// synchronous RAM with a one-cycle registered read. The controller steers the
// RAM read address one step ahead on a pop. The head word is flagged valid
// only once it was already in the RAM before the read that fetched it. The
// consumer therefore never sees the RAM latency or a read-during-write hazard.

// Dual-port RAM: one write port and one registered read port.
// A read of the address written in the same cycle returns the old contents.
module ssram16dp_array #(
  parameter int width = 8,
  parameter int depth = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] waddress,
  input  logic [$clog2(depth)-1:0] raddress,
  input  logic [width-1:0]         dataIn,
  output logic [width-1:0]         dataOut
);

  logic [width-1:0] mem [depth];

  // Write port: store dataIn when we is high.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddress] <= dataIn;
    end
  end

  // Registered read port: the new value appears one cycle after the address.
  always_ff @(posedge clk) begin
    dataOut <= mem[raddress];
  end

endmodule

module ssram_fifo_reader #(
  parameter int width = 8,
  parameter int depth = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [width-1:0]       wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [width-1:0]       rd_data,
  output logic [$clog2(depth):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [CW-1:0] settled_after_pop;
  logic          rd_valid_reg;
  logic          rd_valid_next;
  logic          overflow_reg;
  logic          overflow_next;
  logic          push;
  logic          pop;
  logic [AW-1:0] raddress;

  // Handshakes. wr_ready looks only at the registered count, so a pop in the
  // same cycle frees its slot one cycle later.
  assign wr_ready = (count_reg != CW'(depth));
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid_reg & rd_ready;

  // The read address runs one step ahead on a pop. The word fetched at this
  // edge is then the head that follows the pop.
  assign raddress = rd_ptr_next;

  // Next-state logic for the pointers, occupancy, head visibility and overflow.
  always_comb begin
    wr_ptr_next       = wr_ptr_reg;
    rd_ptr_next       = rd_ptr_reg;
    count_next        = count_reg;
    settled_after_pop = count_reg;
    rd_valid_next     = 1'b0;
    overflow_next     = 1'b0;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    // count_reg words were written at earlier edges, so the RAM already holds
    // them for this edge's read. A word written at this very edge is not
    // readable yet, because the RAM returns old data. The head is valid after
    // this edge only if a settled word remains once the pop is taken out.
    // A pop implies rd_valid, and rd_valid implies count_reg >= 1, so the
    // subtraction cannot wrap.
    settled_after_pop = count_reg - CW'(pop);
    rd_valid_next     = (settled_after_pop != '0);

    // A word offered while full is dropped and reported on the next cycle.
    overflow_next = wr_valid & ~wr_ready;
  end

  // State registers with asynchronous reset. RAM contents are left as they are.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_valid_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      rd_valid_reg <= rd_valid_next;
      overflow_reg <= overflow_next;
    end
  end

  assign rd_valid = rd_valid_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;

  ssram16dp_array #(
    .width (width),
    .depth (depth)
  ) u_ram (
    .clk      (clk),
    .we       (push),
    .waddress (wr_ptr_reg),
    .raddress (raddress),
    .dataIn   (wr_data),
    .dataOut  (rd_data)
  );

endmodule

// File: tb/tb_ssram_fifo_reader.sv
// Self-checking bench for ssram_fifo_reader (width=8, depth=32). A scoreboard
// queue holds each accepted word and the edge on which it was pushed. The
// expected outputs follow from the queue: the head is visible once one more
// edge has passed after its push edge.
module tb_ssram_fifo_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic [5:0]       count;
  logic             overflow;

  typedef struct {
    logic [WIDTH-1:0] data;
    int unsigned      edge_n;
  } ent_t;

  ent_t        q[$];
  int unsigned edge_cnt = 0;
  logic        exp_ovf = 1'b0;
  int          tests = 0;
  int          fails = 0;
  int          pops = 0;
  int          max_cnt = 0;

  ssram_fifo_reader #(.width(WIDTH), .depth(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive the inputs, check the outputs against the model,
  // then advance across the rising edge and update the scoreboard.
  task automatic step(input logic wv, input logic [WIDTH-1:0] wd, input logic rr);
    logic exp_wr_ready;
    logic exp_rd_valid;
    logic do_push;
    logic do_pop;
    logic ovf_next;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    exp_wr_ready = (q.size() != DEPTH);
    exp_rd_valid = (q.size() != 0) && (q[0].edge_n + 1 <= edge_cnt);

    tests++;
    if (wr_ready !== exp_wr_ready) begin
      fails++;
      $display("FAIL wr_ready edge=%0d got=%b exp=%b", edge_cnt, wr_ready, exp_wr_ready);
    end
    tests++;
    if (rd_valid !== exp_rd_valid) begin
      fails++;
      $display("FAIL rd_valid edge=%0d got=%b exp=%b", edge_cnt, rd_valid, exp_rd_valid);
    end
    tests++;
    if (count !== 6'(q.size())) begin
      fails++;
      $display("FAIL count edge=%0d got=%0d exp=%0d", edge_cnt, count, q.size());
    end
    tests++;
    if (overflow !== exp_ovf) begin
      fails++;
      $display("FAIL overflow edge=%0d got=%b exp=%b", edge_cnt, overflow, exp_ovf);
    end
    if (exp_rd_valid) begin
      tests++;
      if (rd_data !== q[0].data) begin
        fails++;
        $display("FAIL rd_data edge=%0d got=%h exp=%h", edge_cnt, rd_data, q[0].data);
      end
    end

    do_push  = wv && exp_wr_ready;
    do_pop   = exp_rd_valid && rr;
    ovf_next = wv && !exp_wr_ready;
    if (do_pop) begin
      $display("[TB] pop  edge=%0d data=%h", edge_cnt, q[0].data);
    end

    @(posedge clk);
    edge_cnt++;
    #1;
    if (do_pop) begin
      void'(q.pop_front());
      pops++;
    end
    if (do_push) begin
      q.push_back('{data: wd, edge_n: edge_cnt});
    end
    exp_ovf = ovf_next;
    if (q.size() > max_cnt) max_cnt = q.size();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (rd_valid !== 1'b0 || count !== 6'd0 || wr_ready !== 1'b1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_state got rv=%b cnt=%0d wr=%b ovf=%b exp rv=0 cnt=0 wr=1 ovf=0",
               rd_valid, count, wr_ready, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    tests++;
    if (wr_ready !== 1'b0 || count !== 6'd32 || rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      fails++;
      $display("FAIL fill_full got wr=%b cnt=%0d rv=%b data=%h exp wr=0 cnt=32 rv=1 data=00",
               wr_ready, count, rd_valid, rd_data);
    end
    drain(DEPTH);
    tests++;
    if (rd_valid !== 1'b0 || count !== 6'd0) begin
      fails++;
      $display("FAIL drain_empty got rv=%b cnt=%0d exp rv=0 cnt=0", rd_valid, count);
    end
  endtask

  task automatic test_latency();
    step(1'b1, 8'hA5, 1'b0);
    tests++;
    if (rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_e0 got rv=%b exp rv=0", rd_valid);
    end
    step(1'b0, '0, 1'b0);
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
      fails++;
      $display("FAIL latency_e1 got rv=%b data=%h exp rv=1 data=a5", rd_valid, rd_data);
    end
    drain(2);
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] seen [$];
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    tests++;
    if (overflow !== 1'b1 || count !== 6'd32) begin
      fails++;
      $display("FAIL overflow_pulse got ovf=%b cnt=%0d exp ovf=1 cnt=32", overflow, count);
    end
    step(1'b0, '0, 1'b0);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow_clear got ovf=%b exp ovf=0", overflow);
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (rd_valid === 1'b1) seen.push_back(rd_data);
      step(1'b0, '0, 1'b1);
    end
    tests++;
    if (seen.size() != DEPTH) begin
      fails++;
      $display("FAIL overflow_drain_len got=%0d exp=%0d", seen.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        tests++;
        if (seen[i] !== 8'(i)) begin
          fails++;
          $display("FAIL overflow_seq idx=%0d got=%h exp=%h", i, seen[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_streaming();
    int p0;
    p0 = pops;
    max_cnt = 0;
    for (int i = 0; i < 100; i++) step(1'b1, 8'(i), 1'b1);
    tests++;
    if (max_cnt > 2) begin
      fails++;
      $display("FAIL stream_count got max=%0d exp<=2", max_cnt);
    end
    tests++;
    if (pops - p0 < 2 * DEPTH) begin
      fails++;
      $display("FAIL stream_wraps got pops=%0d exp>=%0d", pops - p0, 2 * DEPTH);
    end
    drain(4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if (i < 1000) step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 4) < 2));
      else          step(($urandom_range(0, 4) < 2), 8'($urandom), ($urandom_range(0, 3) != 0));
    end
    drain(DEPTH + 2);
    tests++;
    if (q.size() != 0 || count !== 6'd0) begin
      fails++;
      $display("FAIL random_final got cnt=%0d exp=0", count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b0, '0, 1'b0);
    tests++;
    if (count !== 6'd10) begin
      fails++;
      $display("FAIL reset_mid_pre got cnt=%0d exp=10", count);
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (rd_valid !== 1'b0 || count !== 6'd0 || wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid got rv=%b cnt=%0d wr=%b exp rv=0 cnt=0 wr=1", rd_valid, count, wr_ready);
    end
    q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, '0, 1'b0);
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
      fails++;
      $display("FAIL reset_mid_readback got rv=%b data=%h exp rv=1 data=3c", rd_valid, rd_data);
    end
    drain(2);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_latency();
    test_overflow();
    test_streaming();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ssram_fifo_reader.md
Name: ssram_fifo_reader

Overview:
- Synchronous FIFO controller for the UART echo path.
- Owns one `ssram16dp_array` instance and drives its write port from a producer handshake (UART RX side).
- Presents a first-word-fall-through valid/ready read interface to the consumer (UART TX side).
- Generates both RAM addresses, tracks occupancy, and hides the RAM's one-cycle registered read latency from the consumer.

Parameters:
- width, 8, data word width in bits; passed to `ssram16dp_array`.
- depth, 32, number of entries; must be a power of two, at least 4; passed to `ssram16dp_array`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_valid  input  1  producer has a word on wr_data.
- wr_ready  output  1  FIFO can accept a word this cycle.
- wr_data  input  width  word to enqueue.
- rd_valid  output  1  rd_data holds the oldest unread word.
- rd_ready  input  1  consumer takes rd_data this cycle.
- rd_data  output  width  oldest word; driven directly from the RAM's dataOut.
- count  output  $clog2(depth)+1  number of accepted, not-yet-popped words (0..depth).
- overflow  output  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, overflow=0, wr_ready=1.
  - RAM contents are not cleared; rd_data is don't-care while rd_valid=0.
  - Reset mid-operation discards all stored words; the first write after release lands at address 0.
- Push = wr_valid & wr_ready.
  - On a push: RAM we=1, waddress=wr_ptr, dataIn=wr_data.
  - wr_ptr increments and wraps depth-1 -> 0.
- Pop = rd_valid & rd_ready; rd_ptr increments and wraps.
- wr_ready = (count != depth).
  - Combinational from registered count only; a pop in the same cycle does not free a slot until the next cycle.
- wr_valid while full: word dropped, pointers and count unchanged, overflow=1 for the following cycle.
- count_next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - Must never exceed depth or go below 0.
- RAM read port is registered with one-cycle latency.
  - raddress = pop ? rd_ptr+1 : rd_ptr (wrapped), so rd_data at the next edge is the new head.
  - Sustained pop with rd_ready=1 gives one word per cycle, with no bubbles while the FIFO holds at least 2 visible words.
- Visibility rule: a word pushed at edge E is readable (rd_valid=1, correct rd_data) from the cycle after edge E+1.
  - Empty FIFO, push at E0 -> rd_valid rises after E1; latency from wr_valid to rd_valid is 2 cycles.
  - count=1 with pop and push at the same edge: rd_valid drops for exactly one cycle (bubble), then returns with the new word.
  - Must never present stale RAM data with rd_valid=1, including same-address write/read collisions. RAM read-during-write returns old data.
- rd_valid is a registered output. It is never asserted when count=0.
- rd_ready while rd_valid=0 has no effect.
- Pointer wrap: after depth pushes and depth pops, wr_ptr=rd_ptr=0 and count=0; the FIFO state matches post-reset apart from RAM contents.
- Data ordering: strict FIFO; every accepted word is popped exactly once, in order.

Test Plan (width=8, depth=32):
- Fill/drain:
  - Stimulus: push 0..31 back-to-back with rd_ready=0.
  - Required: wr_ready=0 and count=32 after the 32nd push; rd_valid=1 with rd_data=0.
  - Then hold rd_ready=1: pops 0..31 on consecutive cycles, then rd_valid=0 and count=0.
- Latency:
  - Stimulus: empty FIFO, single push of 0xA5 at edge E0.
  - Required: rd_valid=0 in the cycle after E0; rd_valid=1 and rd_data=0xA5 in the cycle after E1.
- Overflow:
  - Stimulus: full FIFO, push 0xFF.
  - Required: overflow pulses high for one cycle, count stays 32, and the drained sequence is still 0..31 with no 0xFF.
- Streaming:
  - Stimulus: wr_valid=1 and rd_ready=1 continuously with an incrementing pattern for 100 cycles.
  - Required: output is the exact incrementing sequence; count stays ≤2; the only bubbles occur at count=1 collisions; at least 2 wraps of both pointers.
- Random:
  - Stimulus: $urandom on wr_valid and rd_ready for 2000 cycles, with a scoreboard queue.
  - Required: no mismatch, no underflow, count always equals the scoreboard size.
- Reset mid-operation:
  - Stimulus: count=10, assert rst asynchronously between edges.
  - Required: rd_valid=0, count=0, wr_ready=1 immediately. The next push of 0x3C reads back as 0x3C.
